dma_master_ctrl: RTL
====================

Name: dma_master_ctrl

Overview:
Single-channel DMA engine. It is programmed through a bus-slave register port and copies a block of words by acting as a bus master: it requests the bus, waits for grant, then runs read/write beats. It attaches to the shared BUS on the master-1 request/grant/address/data lines and also occupies one slave select window for configuration. It raises an interrupt on completion.

Parameters:
ADDR_W, 16, bus address width (word addresses).
DATA_W, 32, bus data width.
SIZE_W, 8, width of the word-count register (max 255 words per transfer).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
s_sel  input  1  slave select for the register window, from BUS.
s_wr  input  1  register write strobe (1 = write, 0 = read).
s_addr  input  ADDR_W  register address; offset is s_addr[4:2].
s_din  input  DATA_W  register write data.
s_dout  output  DATA_W  register read data, registered.
m_req  output  1  bus request.
m_grant  input  1  bus grant from the BUS arbiter.
m_wr  output  1  master write enable.
m_addr  output  ADDR_W  master address.
m_dout  output  DATA_W  master write data.
m_din  input  DATA_W  master read data from BUS.
interrupt  output  1  transfer-done interrupt, level.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. On reset:
  - state goes to IDLE;
  - SRC, DST, SIZE, buffer and word counter clear to 0;
  - int_flag and int_en clear to 0;
  - all outputs (s_dout, m_req, m_wr, m_addr, m_dout, interrupt) go to 0.
  - Reset mid-transfer abandons the transfer immediately and m_req drops asynchronously.
- Register map, offset = s_addr[4:2]:
  - 0 SRC[ADDR_W-1:0], R/W.
  - 1 DST[ADDR_W-1:0], R/W.
  - 2 SIZE[SIZE_W-1:0], R/W.
  - 3 START, W only. Writing bit0=1 starts a transfer; reads as 0.
  - 4 INT_FLAG bit0, R/W. Writing 0 clears it; writing 1 has no effect.
  - 5 INT_EN bit0, R/W.
  - 6 STATUS, R only. bit0 = busy (state != IDLE); bits[15:8] = words remaining.
  - Offset 7 and other unused bits read 0.
- Register writes (s_sel & s_wr) take effect at the clock edge.
- Writes to SRC, DST or SIZE while busy are ignored. START while busy is ignored.
- Register reads: s_sel & ~s_wr in cycle N puts the data on s_dout from cycle N+1. s_dout holds its value otherwise.
- Read latency of the bus: a slave's m_din is valid in the cycle after m_addr is presented with m_wr=0.
- State machine (IDLE, REQ, RD, RDWAIT, WR, DONE):
  - IDLE: on START with SIZE != 0, latch cur_src=SRC, cur_dst=DST, cnt=SIZE, then go to REQ. On START with SIZE == 0, go directly to DONE with no bus activity.
  - REQ: m_req=1. When m_grant=1, go to RD.
  - RD: m_addr=cur_src, m_wr=0, then go to RDWAIT.
  - RDWAIT: m_addr=cur_src, m_wr=0. Capture m_din into buf at the end of the cycle, then go to WR.
  - WR: m_addr=cur_dst, m_wr=1, m_dout=buf. Then cur_src+1, cur_dst+1, cnt-1. If the new cnt is 0 go to DONE, else go to RD.
  - DONE: m_req=0, set int_flag=1, then go to IDLE. DONE lasts 1 cycle.
- m_req is 1 in REQ, RD, RDWAIT and WR, and 0 elsewhere.
- m_wr is 1 only in WR. m_addr and m_dout are 0 when not in RD, RDWAIT or WR.
- Grant loss: if m_grant=0 while in RD, RDWAIT or WR, the state, counters and outputs freeze (m_wr forced to 0) until grant returns. RDWAIT then re-captures m_din.
- Throughput: 3 cycles per word after grant. Total from grant to DONE is 3*SIZE cycles.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000. No boundary checks.
- interrupt = int_flag & int_en, combinational from the registers.
- If a software clear of INT_FLAG and the DONE set land in the same cycle, the set wins.

Test Plan:
1. Reset: pulse reset_n low mid-transfer -> all outputs 0, STATUS reads 0, and the next START works normally.
2. Program SRC=0x0000, DST=0x0100, SIZE=3, INT_EN=1, START. Grant after 2 cycles. s0 model returns 0x11, 0x22, 0x33 -> writes appear at 0x0100..0x0102 with the same data. interrupt rises exactly 9 cycles after grant.
3. SIZE=0 START -> no m_req assertion; INT_FLAG=1 one cycle later; writing INT_FLAG=0 clears interrupt.
4. Drop m_grant for 4 cycles during WR of word 2 of 4 -> m_wr low while grant is low, no skipped or duplicated address, all 4 words copied correctly.
5. SRC=0xFFFF, SIZE=2 -> reads 0xFFFF then 0x0000. While busy, write SIZE=9 and START -> both ignored; STATUS busy=1 with the remaining count decrementing.
6. Register readback: write SRC=0x0200, DST=0x0300 -> reads return 0x0000_0200 and 0x0000_0300 one cycle after the read strobe; offset 7 reads 0.

Source files
------------

// File: rtl/dma_master_ctrl.sv
// Single-channel DMA engine: register slave port for programming, bus master
// that copies SIZE words from SRC to DST, level interrupt on completion.
module dma_master_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              interrupt
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RDWAIT, WR, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] src, dst, cur_src, cur_dst;
    logic [SIZE_W-1:0] size, cnt;
    logic [DATA_W-1:0] data_buf, rdata;
    logic              int_flag, int_en;
    logic [2:0]        off;
    logic              wr_en, rd_en, busy, start;
    logic              unused_bits;

    assign off   = s_addr[4:2];
    assign wr_en = s_sel & s_wr;
    assign rd_en = s_sel & ~s_wr;
    assign busy  = (state != IDLE);
    assign start = wr_en && (off == 3'd3) && s_din[0];
    assign unused_bits = ^{s_addr[ADDR_W-1:5], s_addr[1:0], s_din[DATA_W-1:ADDR_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Bus phases only advance while granted; otherwise everything holds.
    always_comb begin
        state_nx = state;
        m_req    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_dout   = '0;
        case (state)
            IDLE:   if (start) state_nx = (size == '0) ? DONE : REQ;
            REQ: begin
                m_req = 1'b1;
                if (m_grant) state_nx = RD;
            end
            RD: begin
                m_req  = 1'b1;
                m_addr = cur_src;
                if (m_grant) state_nx = RDWAIT;
            end
            RDWAIT: begin
                m_req  = 1'b1;
                m_addr = cur_src;
                if (m_grant) state_nx = WR;
            end
            WR: begin
                m_req  = 1'b1;
                m_wr   = m_grant;
                m_addr = cur_dst;
                m_dout = data_buf;
                if (m_grant) state_nx = (cnt == SIZE_W'(1)) ? DONE : RD;
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_src  <= '0;
            cur_dst  <= '0;
            cnt      <= '0;
            data_buf <= '0;
        end else begin
            if (state == IDLE && start && size != '0) begin
                cur_src <= src;
                cur_dst <= dst;
                cnt     <= size;
            end
            if (state == RDWAIT && m_grant) data_buf <= m_din;
            if (state == WR && m_grant) begin
                cur_src <= cur_src + 1'b1;
                cur_dst <= cur_dst + 1'b1;
                cnt     <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src      <= '0;
            dst      <= '0;
            size     <= '0;
            int_en   <= 1'b0;
            int_flag <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (off)
                    3'd0:    src  <= s_din[ADDR_W-1:0];
                    3'd1:    dst  <= s_din[ADDR_W-1:0];
                    3'd2:    size <= s_din[SIZE_W-1:0];
                    default: ;
                endcase
            end
            if (wr_en && off == 3'd5) int_en <= s_din[0];
            if (wr_en && off == 3'd4 && !s_din[0]) int_flag <= 1'b0;
            // Completion set is placed last so it beats a same-cycle clear.
            if (state_nx == DONE && state != DONE) int_flag <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            3'd0: rdata[ADDR_W-1:0] = src;
            3'd1: rdata[ADDR_W-1:0] = dst;
            3'd2: rdata[SIZE_W-1:0] = size;
            3'd4: rdata[0]          = int_flag;
            3'd5: rdata[0]          = int_en;
            3'd6: begin
                rdata[0]          = busy;
                rdata[8 +: SIZE_W] = cnt;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   s_dout <= '0;
        else if (rd_en) s_dout <= rdata;
    end

    assign interrupt = int_flag & int_en;

endmodule
